sprite_animator: RTL

Parametrised walk-cycle animator for keyboard-driven sprites. It sits between the keycode decoder and the sprite ROM address logic, and converts left/right keycodes into a facing bit and a frame index. Frames advance only on a frame strobe, at a programmable hold rate, so animation speed is independent of the pixel clock and of keyboard repeat. It adds an explicit turn phase on direction reversal and an optional ping-pong frame order.

---
 rtl/sprite_animator_if.sv | 31 +++
 rtl/sprite_animator.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_animator_if.sv
// Bus between the keycode decoder side and the sprite animator.
// The master drives the frame strobe and keycode; the slave (the animator)
// returns facing, frame index, moving flag and step pulse.
interface sprite_animator_if #(
  parameter int FRAME_W = 2
);
  logic               Tick;
  logic [7:0]         Keycode;
  logic               Facing;
  logic [FRAME_W-1:0] Frame;
  logic               Moving;
  logic               Step;

  modport master (
    output Tick,
    output Keycode,
    input  Facing,
    input  Frame,
    input  Moving,
    input  Step
  );

  modport slave (
    input  Tick,
    input  Keycode,
    output Facing,
    output Frame,
    output Moving,
    output Step
  );
endinterface

// File: rtl/sprite_animator.sv
// Walk-cycle animator: turns left/right keycodes into a facing bit and a
// frame index that advances every HOLD_TICKS frame strobes while walking.
// A reversal passes through a TURN phase of HOLD_TICKS strobes at frame 0.
// Optional feature macro: SPRITE_ANIM_PINGPONG_EN selects ping-pong frame
// order (0..N-1..0) instead of wrap order (0..N-1,0).
module sprite_animator #(
  parameter int          NUM_FRAMES = 4,
  parameter int          FRAME_W    = 2,
  parameter int          HOLD_TICKS = 4,
  parameter logic [7:0]  KEY_RIGHT  = 8'd79,
  parameter logic [7:0]  KEY_LEFT   = 8'd80
) (
  input  logic              Clk,
  input  logic              Reset,
  sprite_animator_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    TURN = 2'd2
  } state_t;

  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);
  localparam logic [7:0]         HOLD_LAST  = 8'(HOLD_TICKS - 1);

  state_t             state_q, state_d;
  logic [7:0]         hold_q, hold_d;
  logic               facing_q, facing_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               moving_q, moving_d;
  logic               step_q, step_d;
  logic [FRAME_W-1:0] frame_adv;

  logic is_right, is_left, same_key, opp_key;

  // Classify the keycode relative to the current facing direction.
  always_comb begin
    is_right = (bus.Keycode == KEY_RIGHT);
    is_left  = (bus.Keycode == KEY_LEFT);
    same_key = facing_q ? is_left  : is_right;
    opp_key  = facing_q ? is_right : is_left;
  end

`ifdef SPRITE_ANIM_PINGPONG_EN
  logic pp_dn_q, pp_dn_d, pp_dn_adv;

  // Ping-pong next frame: bounce at both ends, each endpoint shown once.
  always_comb begin
    frame_adv = frame_q;
    pp_dn_adv = pp_dn_q;
    if (!pp_dn_q) begin
      if (frame_q == FRAME_LAST) begin
        frame_adv = frame_q - FRAME_ONE;
        pp_dn_adv = 1'b1;
      end else begin
        frame_adv = frame_q + FRAME_ONE;
      end
    end else begin
      if (frame_q == '0) begin
        frame_adv = FRAME_ONE;
        pp_dn_adv = 1'b0;
      end else begin
        frame_adv = frame_q - FRAME_ONE;
      end
    end
  end
`else
  // Wrap-order next frame: last frame returns to 0.
  always_comb begin
    frame_adv = (frame_q == FRAME_LAST) ? '0 : frame_q + FRAME_ONE;
  end
`endif

  // Next-state and registered-output logic; only Tick cycles change anything.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    facing_d = facing_q;
    frame_d  = frame_q;
    step_d   = 1'b0;
`ifdef SPRITE_ANIM_PINGPONG_EN
    pp_dn_d  = pp_dn_q;
`endif
    if (bus.Tick) begin
      case (state_q)
        IDLE: begin
          if (is_right || is_left) begin
            state_d  = WALK;
            facing_d = is_left;
            frame_d  = '0;
            hold_d   = '0;
          end
        end
        WALK: begin
          if (same_key) begin
            if (hold_q < HOLD_LAST) begin
              hold_d = hold_q + 8'd1;
            end else begin
              hold_d  = '0;
              frame_d = frame_adv;
              step_d  = 1'b1;
`ifdef SPRITE_ANIM_PINGPONG_EN
              pp_dn_d = pp_dn_adv;
`endif
            end
          end else if (opp_key) begin
            state_d  = TURN;
            facing_d = ~facing_q;
            frame_d  = '0;
            hold_d   = '0;
`ifdef SPRITE_ANIM_PINGPONG_EN
            pp_dn_d  = 1'b0;
`endif
          end else begin
            state_d = IDLE;
            frame_d = '0;
            hold_d  = '0;
`ifdef SPRITE_ANIM_PINGPONG_EN
            pp_dn_d = 1'b0;
`endif
          end
        end
        TURN: begin
          if (same_key) begin
            if (hold_q < HOLD_LAST) begin
              hold_d = hold_q + 8'd1;
            end else begin
              state_d = WALK;
              hold_d  = '0;
            end
          end else if (opp_key) begin
            facing_d = ~facing_q;
            hold_d   = '0;
          end else begin
            state_d = IDLE;
            frame_d = '0;
            hold_d  = '0;
`ifdef SPRITE_ANIM_PINGPONG_EN
            pp_dn_d = 1'b0;
`endif
          end
        end
        default: begin
          state_d = IDLE;
          frame_d = '0;
          hold_d  = '0;
        end
      endcase
    end
    moving_d = (state_d == WALK);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      facing_q <= 1'b0;
      frame_q  <= '0;
      moving_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      facing_q <= facing_d;
      frame_q  <= frame_d;
      moving_q <= moving_d;
      step_q   <= step_d;
    end
  end

`ifdef SPRITE_ANIM_PINGPONG_EN
  // Ping-pong direction register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pp_dn_q <= 1'b0;
    end else begin
      pp_dn_q <= pp_dn_d;
    end
  end
`endif

  assign bus.Facing = facing_q;
  assign bus.Frame  = frame_q;
  assign bus.Moving = moving_q;
  assign bus.Step   = step_q;

endmodule
